mux_4way_16: RTL and testbench



---
 rtl/mux_4way_16_pkg.sv | 16 +
 rtl/mux_4way_16_core.sv | 27 ++
 rtl/mux_4way_16.sv | 57 +++++
 tb/tb_mux_4way_16.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_4way_16_pkg.sv
// Shared width, select encodings and parity helper for the registered 4:1 word mux.
// Pure definitions: no latency, no flow control.
package mux_4way_16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic even_parity(input logic [DEFAULT_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_4way_16_core.sv
// Combinational WIDTH-bit 4:1 selector; every sel value maps to a source.
// Latency: zero. Backpressure: none, the output simply follows the inputs.
module mux_4way_16_core
    import mux_4way_16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/mux_4way_16.sv
// Registered 4:1 word mux; optional registered parity under MUX_4WAY_16_PARITY_EN.
// Latency: one clk from sel/data/en to out. Backpressure: none, en=0 holds out.
module mux_4way_16
    import mux_4way_16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             en,
`ifdef MUX_4WAY_16_PARITY_EN
    output logic             out_parity,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_word;

    mux_4way_16_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (sel_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (en) begin
                out <= sel_word;
            end
            out_valid <= en;
        end
    end

`ifdef MUX_4WAY_16_PARITY_EN
    // Registered from the same word as out so the pair never disagrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (en) begin
            out_parity <= ^sel_word;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4way_16.sv
// Randomised and directed bench for mux_4way_16 against a word-array reference model.
module tb_mux_4way_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b, c, d;
    logic [1:0]  sel;
    logic        en;
    logic [15:0] out;
    logic        out_valid;
`ifdef MUX_4WAY_16_PARITY_EN
    logic        out_parity;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    logic [15:0] exp_out;
    logic        exp_vld;

    mux_4way_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .sel        (sel),
        .en         (en),
`ifdef MUX_4WAY_16_PARITY_EN
        .out_parity (out_parity),
`endif
        .out        (out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the register holds whichever word the select named at the last enabled edge.
    always @(posedge clk or negedge rst_n) begin
        logic [15:0] words [4];
        if (!rst_n) begin
            exp_out <= 16'h0000;
            exp_vld <= 1'b0;
        end else begin
            words[0] = a;
            words[1] = b;
            words[2] = c;
            words[3] = d;
            if (en) exp_out <= words[sel];
            exp_vld <= en;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_out", {16'h0, out}, {16'h0, exp_out});
            chk("model_valid", {31'h0, out_valid}, {31'h0, exp_vld});
`ifdef MUX_4WAY_16_PARITY_EN
            chk("model_parity", {31'h0, out_parity}, {31'h0, ^exp_out});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b1;
        a = 16'hAAAA; b = 16'hBBBB; c = 16'hCCCC; d = 16'hDDDD;
        sel = 2'b00; en = 1'b1;

        // Reset takes effect before the first clock edge at t=5.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_async", {16'h0, out}, 32'h0);
        chk("reset_valid_async", {31'h0, out_valid}, 32'h0);
        chk_on = 1'b1;
        tick(); tick();
        chk("reset_out_hold", {16'h0, out}, 32'h0);
        chk("reset_valid_hold", {31'h0, out_valid}, 32'h0);
        rst_n = 1'b1;

        // Select sweep, each word one cycle late.
        sel = 2'b00; tick();
        chk("sweep_a", {16'h0, out}, 32'hAAAA);
        chk("sweep_valid_a", {31'h0, out_valid}, 32'h1);
        sel = 2'b01; tick();
        chk("sweep_b", {16'h0, out}, 32'hBBBB);
        sel = 2'b10; tick();
        chk("sweep_c", {16'h0, out}, 32'hCCCC);
        sel = 2'b11; tick();
        chk("sweep_d", {16'h0, out}, 32'hDDDD);
        chk("sweep_valid_d", {31'h0, out_valid}, 32'h1);

        // Hold with en low.
        sel = 2'b10; tick();
        chk("load_c", {16'h0, out}, 32'hCCCC);
        en = 1'b0; sel = 2'b11; tick();
        chk("hold_out", {16'h0, out}, 32'hCCCC);
        chk("hold_valid", {31'h0, out_valid}, 32'h0);

        // Mid-cycle select glitches never reach out.
        en = 1'b1; sel = 2'b01;
        #1 sel = 2'b11;
        #1 sel = 2'b00;
        #1 sel = 2'b10;
        chk("glitch_no_leak", {16'h0, out}, 32'hCCCC);
        #1 sel = 2'b01;
        tick();
        chk("glitch_out", {16'h0, out}, 32'hBBBB);

        // Async reset pulse mid-stream, then reload.
        sel = 2'b11; tick();
        chk("stream_d", {16'h0, out}, 32'hDDDD);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out", {16'h0, out}, 32'h0);
        chk("midreset_valid", {31'h0, out_valid}, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("reload_d", {16'h0, out}, 32'hDDDD);
        chk("reload_valid", {31'h0, out_valid}, 32'h1);

`ifdef MUX_4WAY_16_PARITY_EN
        d = 16'h0001; sel = 2'b11; tick();
        chk("parity_one", {31'h0, out_parity}, 32'h1);
        a = 16'h0003; sel = 2'b00; tick();
        chk("parity_two", {31'h0, out_parity}, 32'h0);
`endif

        // Random traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            c   = 16'($urandom);
            d   = 16'($urandom);
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
